fetch_sequencer: RTL and testbench

Controller that owns the program counter and sequences the instruction-fetch stage. Drives the instruction-memory address and request, waits on memory readiness, honours load-use stalls, takes branch/jump redirects from EX with an IF/ID flush, and stops fetching on halt or a misaligned target. Sits between the hazard/branch logic and the IF/ID pipeline register.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_next_pc.sv | 59 +++++
 rtl/fetch_sequencer.sv | 80 ++++++++
 tb/tb_fetch_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned CNT_W       = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Priority select of next PC/state and same-cycle fetch controls:
// redirect > halt > stall > memory response.
module fetch_next_pc
  import fetch_pkg::*;
(
  input  fetch_state_e    state_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            halt_i,
  input  logic            stall_i,
  input  logic            ready_i,
  output fetch_state_e    state_d_o,
  output logic [XLEN-1:0] pc_d_o,
  output logic            req_o,
  output logic            write_o,
  output logic            flush_o,
  output logic            fault_set_o
);

  always_comb begin
    state_d_o   = state_i;
    pc_d_o      = pc_i;
    req_o       = 1'b0;
    write_o     = 1'b0;
    flush_o     = 1'b0;
    fault_set_o = 1'b0;
    case (state_i)
      ST_BOOT: state_d_o = ST_FETCH;
      ST_FETCH, ST_WAIT: begin
        req_o = 1'b1;
        if (redirect_i) begin
          // The flush applies even when the target is rejected as misaligned.
          flush_o = 1'b1;
          if (redirect_pc_i[1:0] == 2'b00) begin
            pc_d_o    = redirect_pc_i;
            state_d_o = ST_FETCH;
          end else begin
            fault_set_o = 1'b1;
            state_d_o   = ST_HALTED;
          end
        end else if (halt_i) begin
          state_d_o = ST_HALTED;
        end else if (!stall_i) begin
          if (ready_i) begin
            write_o   = 1'b1;
            pc_d_o    = pc_i + XLEN'(INSTR_BYTES);
            state_d_o = ST_FETCH;
          end else begin
            state_d_o = ST_WAIT;
          end
        end
      end
      ST_HALTED: state_d_o = ST_HALTED;
      default:   state_d_o = ST_BOOT;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter owner for the IF stage: drives instruction memory and
// the IF/ID register, handling stalls, redirects, halt and alignment faults.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  input  logic             halt_i,
  input  logic             imem_ready_i,
  output logic [XLEN-1:0]  imem_addr_o,
  output logic             imem_req_o,
  output logic [XLEN-1:0]  pc_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             halted_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] fetch_count_o
);

  fetch_state_e     state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pc_out_q;
  logic [CNT_W-1:0] count_q;
  logic             fault_q, halted_q;
  logic             req_c, write_c, flush_c, fault_set_c;

  fetch_next_pc u_next_pc (
    .state_i       (state_q),
    .pc_i          (pc_q),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halt_i        (halt_i),
    .stall_i       (stall_i),
    .ready_i       (imem_ready_i),
    .state_d_o     (state_d),
    .pc_d_o        (pc_d),
    .req_o         (req_c),
    .write_o       (write_c),
    .flush_o       (flush_c),
    .fault_set_o   (fault_set_c)
  );

  // FSM, PC, last-written PC, counter and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      pc_out_q <= RESET_PC;
      count_q  <= '0;
      fault_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= (state_d == ST_HALTED);
      if (write_c) begin
        pc_out_q <= pc_q;
        count_q  <= count_q + CNT_W'(1);
      end
      if (fault_set_c) begin
        fault_q <= 1'b1;
      end
    end
  end

  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_out_q;
  assign fetch_count_o = count_q;
  assign fault_o       = fault_q;
  assign halted_o      = halted_q;
  assign imem_req_o    = req_c;
  assign ifid_write_o  = write_c;
  assign ifid_flush_o  = flush_c;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random
// traffic against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect, halt, ready;
  logic [31:0] redirect_pc;

  logic [31:0] addr0, pc0, cnt0, addr1, pc1, cnt1;
  logic        req0, wr0, fl0, hlt0, flt0;
  logic        req1, wr1, fl1, hlt1, flt1;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          m_booted, m_halted, m_fault;
  logic [31:0] m_pc, m_last, m_count;
  logic        e_req, e_write, e_flush;

  always #5 clk = ~clk;

  fetch_sequencer dut0 (
    .clk(clk), .reset(reset), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .halt_i(halt), .imem_ready_i(ready),
    .imem_addr_o(addr0), .imem_req_o(req0), .pc_o(pc0), .ifid_write_o(wr0),
    .ifid_flush_o(fl0), .halted_o(hlt0), .fault_o(flt0), .fetch_count_o(cnt0)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .reset(reset), .stall_i(stall), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .halt_i(halt), .imem_ready_i(ready),
    .imem_addr_o(addr1), .imem_req_o(req1), .pc_o(pc1), .ifid_write_o(wr1),
    .ifid_flush_o(fl1), .halted_o(hlt1), .fault_o(flt1), .fetch_count_o(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs();
    chk("imem_addr", addr0, m_pc);
    chk("pc_o", pc0, m_last);
    chk("halted", 32'(hlt0), 32'(m_halted));
    chk("fault", 32'(flt0), 32'(m_fault));
    chk("fetch_count", cnt0, m_count);
  endtask

  // Entered just after a falling edge; returns just after the next one.
  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0; redirect = 1'b0; halt = 1'b0; ready = 1'b0;
    redirect_pc = 32'h0;
    m_booted = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
    m_pc = 32'h0; m_last = 32'h0; m_count = 32'h0;
    #1;
    chk_regs();
    chk("rst_req", 32'(req0), 32'h0);
    chk("rst_write", 32'(wr0), 32'h0);
    chk("rst_flush", 32'(fl0), 32'h0);
    chk("rst_addr1", addr1, 32'hFFFF_FFFC);
    chk("rst_pc1", pc1, 32'hFFFF_FFFC);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock cycle: drive, check same-cycle controls, advance model, check registers.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                      input logic hl, input logic rdy);
    stall = st; redirect = rd; redirect_pc = rpc; halt = hl; ready = rdy;
    e_req = 1'b0; e_write = 1'b0; e_flush = 1'b0;
    #1;
    if (!m_booted) begin
      m_booted = 1'b1;
    end else if (!m_halted) begin
      e_req = 1'b1;
      if (rd) begin
        e_flush = 1'b1;
        if (rpc % 4 == 0) m_pc = rpc;
        else begin m_fault = 1'b1; m_halted = 1'b1; end
      end else if (hl) begin
        m_halted = 1'b1;
      end else if (!st && rdy) begin
        e_write = 1'b1;
        m_last  = m_pc;
        m_pc    = m_pc + 32'd4;
        m_count = m_count + 32'd1;
      end
    end
    chk("imem_req", 32'(req0), 32'(e_req));
    chk("ifid_write", 32'(wr0), 32'(e_write));
    chk("ifid_flush", 32'(fl0), 32'(e_flush));
    @(posedge clk);
    #1;
    chk_regs();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0; redirect = 1'b0; halt = 1'b0; ready = 1'b0;
    redirect_pc = 32'h0;
    @(negedge clk);

    // Streaming fetch: BOOT then four accepts; also wrap on the second instance.
    do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("wrap_pc1_a", pc1, 32'hFFFF_FFFC);
    chk("wrap_addr1_a", addr1, 32'h0000_0000);
    step(0, 0, 0, 0, 1);
    chk("wrap_pc1_b", pc1, 32'h0000_0000);
    chk("wrap_cnt1", cnt1, 32'd2);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("count_after_4", cnt0, 32'd4);
    chk("pc_o_after_4", pc0, 32'h0000_000C);

    // Stall two cycles at 0x8, then release.
    do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("stall_hold", addr0, 32'h0000_0008);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("stall_release", pc0, 32'h0000_000C);

    // Redirect together with stall.
    step(1, 1, 32'h0000_0100, 0, 1);
    chk("redirect_target", addr0, 32'h0000_0100);
    step(0, 0, 0, 0, 1);

    // Memory not ready for three cycles at 0x4, then reset mid-WAIT.
    do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("wait_hold", addr0, 32'h0000_0004);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    #2;
    do_reset();

    // Misaligned redirect: fault and permanent halt until reset.
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 32'h0000_0102, 0, 1);
    chk("misalign_fault", 32'(flt0), 32'h1);
    for (int i = 0; i < 4; i++)
      step(1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC, 1'($urandom), 1'($urandom));
    step(0, 0, 0, 0, 1);

    // Explicit halt.
    do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 250; i++) begin
        logic [31:0] tgt;
        tgt = $urandom;
        if ($urandom_range(0, 7) != 0) tgt = tgt & 32'hFFFF_FFFC;
        step(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), tgt,
             ($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
